// File: rtl/cbc_stream_engine.sv
// CBC chaining engine wrapped around an external single-block AES-128 core.
// Per message: seed the chain from iv, then load -> core start/wait -> output, with back-pressure on both streams.
module cbc_stream_engine #(
  parameter int BLK_W = 128,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [BLK_W-1:0] iv,
  output logic             busy,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             core_start,
  output logic             core_mode,
  output logic [BLK_W-1:0] core_in,
  input  logic [BLK_W-1:0] core_out,
  input  logic             core_done,
  output logic [BLK_W-1:0] out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]       r_state;
  logic [BLK_W-1:0] r_chain;
  logic [BLK_W-1:0] r_din;
  logic [BLK_W-1:0] r_out_data;
  logic             r_mode;
  logic             r_last;
  logic [CNT_W-1:0] r_blk_cnt;
  logic [BLK_W-1:0] w_core_in;

  // din and chain do not move between START and core_done, so the core input is stable without its own register
  assign w_core_in = r_mode ? r_din : (r_din ^ r_chain);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_chain    <= '0;
      r_din      <= '0;
      r_out_data <= '0;
      r_mode     <= 1'b0;
      r_last     <= 1'b0;
      r_blk_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_chain   <= iv;
            r_mode    <= mode;
            r_blk_cnt <= '0;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            r_din   <= in_data;
            r_last  <= in_last;
            r_state <= S_START;
          end
        end
        S_START, S_WAIT: begin
          // a zero-latency core answers during START and is taken there directly
          if (core_done) begin
            r_state <= S_OUT;
            if (r_mode) begin
              r_out_data <= core_out ^ r_chain;
              r_chain    <= r_din;
            end else begin
              r_out_data <= core_out;
              r_chain    <= core_out;
            end
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_blk_cnt <= r_blk_cnt + CNT_W'(1);
            r_state   <= r_last ? S_IDLE : S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign in_ready   = (r_state == S_LOAD);
  assign core_start = (r_state == S_START);
  assign core_mode  = r_mode;
  assign core_in    = w_core_in;
  assign out_valid  = (r_state == S_OUT);
  assign out_last   = r_last && (r_state == S_OUT);
  assign out_data   = r_out_data;
  assign blk_cnt    = r_blk_cnt;

endmodule

// File: tb/tb_cbc_stream_engine.sv
// Bench for cbc_stream_engine: behavioural AES-128 core on the core port, CBC reference model, random traffic.
module tb_cbc_stream_engine;

  logic         clk = 1'b0;
  logic         rst_n, start, mode, in_last, in_valid;
  logic [127:0] iv, in_data;
  logic         out_ready = 1'b0;
  logic         core_done = 1'b0;
  logic [127:0] core_out = '0;
  logic         busy, in_ready, core_start, core_mode, out_last, out_valid;
  logic [127:0] core_in, out_data;
  logic [15:0]  blk_cnt;

  always #5 clk = ~clk;

  cbc_stream_engine #(.BLK_W(128), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .iv(iv), .busy(busy),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .core_start(core_start), .core_mode(core_mode), .core_in(core_in),
    .core_out(core_out), .core_done(core_done),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .blk_cnt(blk_cnt)
  );

  int n_chk = 0;
  int n_err = 0;
  int lat = 1;
  int rdy_pct = 100;
  bit stray_en = 1'b0;
  int pend = 0;
  int cs_cnt = 0;
  int cyc = 0;
  logic [127:0] pres;
  logic [127:0] blk [8];
  logic [127:0] q_data [$];
  bit           q_last [$];
  int           q_cyc  [$];

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] NIV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CT2 = 128'h5086cb9b507219ee95db113a917678b2;

  // ---------------- AES-128 reference ----------------
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [127:0] rk  [11];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_aes();
    logic [7:0]  inv, s, rc;
    logic [31:0] w [44];
    logic [31:0] t;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] x;
    x = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sb[x[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      for (int k = 0; k < 16; k++) x[127-8*k -: 8] = t[k];
      x = x ^ rk[r];
    end
    return x;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] x;
    x = ct ^ rk[10];
    for (int r = 9; r >= 0; r--) begin
      for (int k = 0; k < 16; k++) s[k] = x[127-8*k -: 8];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*((c+rr)%4)] = s[rr+4*c];
      for (int k = 0; k < 16; k++) x[127-8*k -: 8] = isb[t[k]];
      x = x ^ rk[r];
      if (r > 0) begin
        for (int k = 0; k < 16; k++) t[k] = x[127-8*k -: 8];
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
          t[4*c+1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
          t[4*c+2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
          t[4*c+3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
        end
        for (int k = 0; k < 16; k++) x[127-8*k -: 8] = t[k];
      end
    end
    return x;
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- core model, sink, monitor ----------------
  always @(negedge clk) begin
    core_done = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin core_done = 1'b1; core_out = pres; end
    end
    if (core_start === 1'b1) begin
      cs_cnt = cs_cnt + 1;
      pres = core_mode ? aes_dec(core_in) : aes_enc(core_in);
      if (lat == 0) begin core_done = 1'b1; core_out = pres; pend = 0; end
      else pend = lat;
    end else if (stray_en && in_ready === 1'b1 && !core_done && $urandom_range(0, 1) == 1) begin
      core_done = 1'b1;
      core_out  = rnd();
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1 out_ready = ($urandom_range(1, 100) <= rdy_pct);
  end

  always @(negedge clk)
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      q_data.push_back(out_data);
      q_last.push_back(out_last);
      q_cyc.push_back(cyc);
    end

  // ---------------- message driver with CBC reference ----------------
  task automatic run_msg(input bit m, input logic [127:0] v, input int n, input bit gaps, input bit noise);
    logic [127:0] prev, e;
    logic [127:0] expq [$];
    int bud, g;
    bud = 0;
    while (busy && bud < 500) begin @(posedge clk); #1; bud++; end
    q_data.delete(); q_last.delete(); q_cyc.delete();
    start = 1'b1; mode = m; iv = v;
    @(posedge clk); #1;
    start = 1'b0;
    n_chk++;
    if (in_ready !== 1'b1 || blk_cnt !== 16'd0) begin
      n_err++; $display("FAIL msg_start: in_ready=%b blk_cnt=%0d, want 1 and 0", in_ready, blk_cnt);
    end
    prev = v;
    for (int i = 0; i < n; i++) begin
      g = gaps ? $urandom_range(0, 2) : 0;
      for (int j = 0; j < g; j++) begin @(posedge clk); #1; end
      in_valid = 1'b1; in_data = blk[i]; in_last = (i == n-1);
      bud = 0;
      while (in_ready !== 1'b1 && bud < 200) begin @(posedge clk); #1; bud++; end
      if (bud >= 200) begin
        n_chk++; n_err++; in_valid = 1'b0; start = 1'b0;
        $display("FAIL in_handshake: block %0d never accepted, want in_ready", i);
        return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      if (noise && i == 0 && n > 1) begin start = 1'b1; mode = ~m; iv = rnd(); end
      if (noise && i == n-1) start = 1'b0;
      if (!m) begin e = aes_enc(blk[i] ^ prev); prev = e; end
      else    begin e = aes_dec(blk[i]) ^ prev; prev = blk[i]; end
      expq.push_back(e);
    end
    bud = 0;
    while (q_data.size() < n && bud < 500) begin @(posedge clk); #1; bud++; end
    n_chk++;
    if (q_data.size() != n) begin
      n_err++; $display("FAIL out_count: got %0d blocks, want %0d", q_data.size(), n);
      return;
    end
    for (int i = 0; i < n; i++) begin
      n_chk++;
      if (q_data[i] !== expq[i] || q_last[i] !== (i == n-1)) begin
        n_err++;
        $display("FAIL out_block%0d: got %h last=%b, want %h last=%b", i, q_data[i], q_last[i], expq[i], (i == n-1));
      end
    end
    n_chk++;
    if (blk_cnt !== 16'(n) || busy !== 1'b0) begin
      n_err++; $display("FAIL msg_end: blk_cnt=%0d busy=%b, want %0d and 0", blk_cnt, busy, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_chk++;
    if ({busy, in_ready, core_start, out_valid, out_last, core_mode} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b, want 000000", {busy, in_ready, core_start, out_valid, out_last, core_mode});
    end
    n_chk++;
    if (out_data !== 128'h0 || core_in !== 128'h0) begin
      n_err++; $display("FAIL reset_data: out_data=%h core_in=%h, want 0", out_data, core_in);
    end
    n_chk++;
    if (blk_cnt !== 16'h0 || dut.r_chain !== 128'h0) begin
      n_err++; $display("FAIL reset_regs: blk_cnt=%0d chain=%h, want 0", blk_cnt, dut.r_chain);
    end
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_chk++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL idle_ignores_valid: in_ready=%b busy=%b, want 0 0", in_ready, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_nist_encrypt();
    lat = 3; rdy_pct = 100;
    blk[0] = PT1; blk[1] = PT2;
    run_msg(1'b0, NIV, 2, 1'b1, 1'b0);
    n_chk++;
    if (q_data[0] !== CT1 || q_data[1] !== CT2 || q_last[0] !== 1'b0 || q_last[1] !== 1'b1) begin
      n_err++; $display("FAIL nist_enc: got %h %h, want %h %h", q_data[0], q_data[1], CT1, CT2);
    end
  endtask

  task automatic test_nist_decrypt();
    lat = 2; rdy_pct = 70;
    blk[0] = CT1; blk[1] = CT2;
    run_msg(1'b1, NIV, 2, 1'b1, 1'b0);
    n_chk++;
    if (q_data[0] !== PT1 || q_data[1] !== PT2) begin
      n_err++; $display("FAIL nist_dec: got %h %h, want %h %h", q_data[0], q_data[1], PT1, PT2);
    end
    n_chk++;
    if (dut.r_chain !== CT2) begin
      n_err++; $display("FAIL dec_chain: got %h, want %h", dut.r_chain, CT2);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] v, e, d0;
    logic l0;
    int cs0, bud;
    rdy_pct = 0; lat = 10; v = rnd(); blk[0] = rnd();
    bud = 0;
    while (busy && bud < 500) begin @(posedge clk); #1; bud++; end
    start = 1'b1; mode = 1'b0; iv = v;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = blk[0]; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    e = aes_enc(blk[0] ^ v);
    bud = 0;
    while (out_valid !== 1'b1 && bud < 50) begin @(posedge clk); #1; bud++; end
    cs0 = cs_cnt; d0 = out_data; l0 = out_last;
    n_chk++;
    if (out_valid !== 1'b1 || d0 !== e || l0 !== 1'b1) begin
      n_err++; $display("FAIL bp_result: got %h last=%b valid=%b, want %h last=1", d0, l0, out_valid, e);
    end
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== d0 || out_last !== l0 || in_ready !== 1'b0 || cs_cnt != cs0) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid=%b data=%h last=%b in_ready=%b starts=%0d, want 1 %h %b 0 %0d",
                 i, out_valid, out_data, out_last, in_ready, cs_cnt, d0, l0, cs0);
      end
    end
    rdy_pct = 100;
    bud = 0;
    while (busy && bud < 50) begin @(posedge clk); #1; bud++; end
    n_chk++;
    if (busy !== 1'b0 || blk_cnt !== 16'd1) begin
      n_err++; $display("FAIL bp_release: busy=%b blk_cnt=%0d, want 0 1", busy, blk_cnt);
    end
  endtask

  task automatic test_reset_wait();
    bit bad;
    rdy_pct = 100; lat = 8; blk[0] = rnd();
    q_data.delete(); q_last.delete(); q_cyc.delete();
    start = 1'b1; mode = 1'b0; iv = rnd();
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = blk[0]; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_chk++;
    if (bad || q_data.size() != 0) begin
      n_err++; $display("FAIL late_done: bad=%b outputs=%0d, want 0 and 0", bad, q_data.size());
    end
    lat = 3; blk[0] = 128'h0;
    run_msg(1'b0, 128'h0, 1, 1'b0, 1'b0);
    n_chk++;
    if (q_data[0] !== 128'h7df76b0c1ab899b33e42f047b91b546f) begin
      n_err++; $display("FAIL aes_k0: got %h, want 7df76b0c1ab899b33e42f047b91b546f", q_data[0]);
    end
  endtask

  task automatic test_ignored();
    stray_en = 1'b1; lat = 1; rdy_pct = 80;
    for (int i = 0; i < 3; i++) blk[i] = rnd();
    run_msg(1'b0, rnd(), 3, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) blk[i] = rnd();
    run_msg(1'b1, rnd(), 3, 1'b1, 1'b1);
    stray_en = 1'b0;
  endtask

  task automatic test_throughput();
    lat = 0; rdy_pct = 100;
    for (int i = 0; i < 4; i++) blk[i] = rnd();
    run_msg(1'b0, rnd(), 4, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      n_chk++;
      if (q_cyc[i] - q_cyc[i-1] != 3) begin
        n_err++; $display("FAIL throughput%0d: spacing %0d cycles, want 3", i, q_cyc[i] - q_cyc[i-1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    rdy_pct = 60;
    for (int k = 0; k < 8; k++) begin
      lat = $urandom_range(0, 4);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) blk[i] = rnd();
      run_msg(k[0], rnd(), n, 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; iv = '0;
    in_data = '0; in_last = 1'b0; in_valid = 1'b0;
    build_aes();
    test_reset();
    test_nist_encrypt();
    test_nist_decrypt();
    test_backpressure();
    test_reset_wait();
    test_ignored();
    test_throughput();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cbc_stream_engine.md
# cbc_stream_engine

Sequential, parametrised CBC chaining engine for the AES-128 datapath. It sits between a block stream and an external single-block AES core, and handles encrypt and decrypt selected per message. It holds the chaining register, sequences the core through a start/done handshake, and streams results out under valid/ready flow control. It replaces fixed-IV, combinational CBC decryption with a multi-message, back-pressured, mode-selectable block.

## Interface
Parameters:
- BLK_W, 128, block width in bits; key, IV, data and core ports all use this width.
- CNT_W, 16, width of the block counter (default covers 65536 blocks per message).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  message start pulse; honoured only in IDLE
- mode  in  1  sampled with start: 0 = encrypt, 1 = decrypt
- iv  in  BLK_W  initial vector, sampled with start
- busy  out  1  high in every state except IDLE
- in_data  in  BLK_W  input block (plaintext for encrypt, ciphertext for decrypt)
- in_last  in  1  marks the final block of the message
- in_valid  in  1  input block valid
- in_ready  out  1  engine accepts a block (LOAD state only)
- core_start  out  1  one-cycle pulse to the AES core
- core_mode  out  1  latched mode, forwarded to the core
- core_in  out  BLK_W  block presented to the core
- core_out  in  BLK_W  core result
- core_done  in  1  core result valid; one-cycle pulse
- out_data  out  BLK_W  result block
- out_last  out  1  result is the final block of the message
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- blk_cnt  out  CNT_W  number of blocks output in the current message

## Operation
- States: IDLE, LOAD, START, WAIT, OUT.
- IDLE:
  - On start=1: chain <= iv, mode_r <= mode, blk_cnt <= 0, go to LOAD.
  - in_valid is ignored in IDLE.
- LOAD:
  - in_ready=1.
  - On in_valid handshake: din_r <= in_data, last_r <= in_last, go to START.
- START:
  - core_start=1 for this cycle only.
  - core_in = din_r ^ chain when encrypting, din_r when decrypting.
  - core_in and core_mode stay stable from START until the cycle core_done is seen.
  - If core_done=1 in START (zero-latency core), treat it as WAIT completion. Otherwise go to WAIT.
- WAIT: on core_done, capture the result and go to OUT.
  - Encrypt: out_data <= core_out; chain <= core_out.
  - Decrypt: out_data <= core_out ^ chain; chain <= din_r.
- OUT:
  - out_valid=1 and out_last=last_r.
  - out_data and out_last hold stable while out_ready=0.
  - On handshake: blk_cnt <= blk_cnt+1 (wraps modulo 2^CNT_W, no flag). Go to IDLE if last_r, else LOAD.
- core_done outside START/WAIT is ignored.
- start outside IDLE is ignored. The chain, mode and counter are not disturbed.
- XOR is bitwise over the full BLK_W. There is no padding; partial blocks are the caller's responsibility.

## Timing
- Reset (rst_n=0 at a clock edge) forces, from the next cycle:
  - state=IDLE; busy=0, in_ready=0, core_start=0, out_valid=0, out_last=0;
  - out_data=0, core_in=0, core_mode=0, blk_cnt=0, chain=0.
- Reset mid-message aborts it. Any later core_done is ignored until a new START.
- All outputs are registered or decoded from state plus registers. There is no combinational path from in_valid/out_ready to in_ready/out_valid.
- Latency: input handshake at cycle N, core_start at N+1, core_done earliest at N+1, out_valid earliest at N+2.
- Throughput with a zero-latency core and out_ready held high is one block per 3 cycles (LOAD, START, OUT).
- start handshake at cycle N gives in_ready=1 at N+1.
- blk_cnt updates in the cycle after the output handshake.

## Test plan
- Encrypt, NIST SP800-38A F.2.1 vectors (behavioural AES model on the core port):
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102030405060708090a0b0c0d0e0f, PT1 6bc1bee22e409f96e93d7e117393172a, PT2 ae2d8a571e03ac9c9eb76fac45af8e51.
  - Required: out 7649abac8119b246cee98e9b12e9197d then 5086cb9b507219ee95db113a917678b2; out_last on block 2; blk_cnt=2; busy=0.
- Decrypt of the same two ciphertexts, same IV:
  - Required: the two plaintexts in order; chain=5086cb9b507219ee95db113a917678b2 before return to IDLE.
- Back-pressure:
  - Stimulus: out_ready=0 for 7 cycles; core latency 10 cycles.
  - Required: out_data, out_valid and out_last stable; in_ready=0; no second core_start.
- Reset during WAIT, then a late core_done:
  - Required: no out_valid. A following encrypt message from IV=0 with PT 0 produces AES_k(0)=7df76b0c1ab899b33e42f047b91b546f.
- Ignored inputs:
  - start mid-message: output sequence unchanged.
  - Stray core_done in LOAD: no state change.
- Back-to-back messages with different modes: chain re-seeds from the new iv, and blk_cnt restarts at 0.
